ttfir_prbs_checker: RTL and testbench

Downstream stage for the FIR core: consumes the core's 1-bit `y_out` stream and checks it against a self-synchronising PRBS7 (x^7 + x^6 + 1) reference. The core is driven upstream with a PRBS7 stimulus. The block reports lock status, single-cycle error strobes and a saturating error count, so the FIR can be verified on silicon without an external bit-error tester. It sits beside `gbsha_top` in the bring-up harness and is clocked by the same `clk`.

---
 rtl/ttfir_prbs_checker_if.sv | 48 ++++
 rtl/ttfir_prbs_checker.sv | 208 ++++++++++++++++++++
 tb/tb_ttfir_prbs_checker.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ttfir_prbs_checker_if.sv
// ---------------------------------------------------------------------------
// ttfir_prbs_checker_if
// Bundles the bit stream, the clear and the status outputs of the PRBS7
// checker that follows the FIR core.
//   y_in      received bit (FIR y_out)
//   y_valid   qualifies y_in
//   clr       synchronous clear of err_cnt (and bit_cnt when present)
//   locked    checker is in LOCKED
//   err_pulse one-cycle strobe per mismatched bit while locked
//   err_cnt   saturating error count, ERR_W bits
//   bit_cnt   locked valid-bit count, only with TTFIR_CHK_BITCNT_EN defined
// modport master: the stream source / status reader (bench or harness).
// modport slave : the checker itself.
// ERR_W must match the checker's ERR_W.
// ---------------------------------------------------------------------------
interface ttfir_prbs_checker_if #(
  parameter int ERR_W = 8
);
  logic             y_in;
  logic             y_valid;
  logic             clr;
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_cnt;
`ifdef TTFIR_CHK_BITCNT_EN
  logic [15:0]      bit_cnt;

  modport master (
    output y_in, y_valid, clr,
    input  locked, err_pulse, err_cnt, bit_cnt
  );

  modport slave (
    input  y_in, y_valid, clr,
    output locked, err_pulse, err_cnt, bit_cnt
  );
`else
  modport master (
    output y_in, y_valid, clr,
    input  locked, err_pulse, err_cnt
  );

  modport slave (
    input  y_in, y_valid, clr,
    output locked, err_pulse, err_cnt
  );
`endif
endinterface

// File: rtl/ttfir_prbs_checker.sv
// ---------------------------------------------------------------------------
// ttfir_prbs_checker
// Checks the FIR core's 1-bit output stream against a self-synchronising
// PRBS7 (x^7 + x^6 + 1) reference. In HUNT the reference register is loaded
// from the received bits; once LOCK_COUNT consecutive predictions match, the
// register free-runs (LOCKED) and every mismatch is reported. Too many errors
// inside one window of WIN valid bits drops back to HUNT.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   bus  ttfir_prbs_checker_if.slave (y_in, y_valid, clr in;
//        locked, err_pulse, err_cnt [, bit_cnt] out)
//
// Optional feature: define TTFIR_CHK_BITCNT_EN to add bit_cnt[15:0], a
// saturating count of valid bits seen while LOCKED (cleared by rst and clr,
// held through HUNT).
// All outputs are registered and reset to 0.
// ---------------------------------------------------------------------------
module ttfir_prbs_checker #(
  parameter int LOCK_COUNT  = 16,  // 2..255
  parameter int WIN         = 32,  // 2..255
  parameter int LOSS_THRESH = 4,   // 1..WIN
  parameter int ERR_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  ttfir_prbs_checker_if.slave  bus
);

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  localparam logic [7:0]       LOCK_C  = 8'(LOCK_COUNT);
  localparam logic [7:0]       WIN_C   = 8'(WIN);
  localparam logic [7:0]       LOSS_C  = 8'(LOSS_THRESH);
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  // Next reference bit of the PRBS7 recurrence b[n] = b[n-7] ^ b[n-6].
  function automatic logic prbs7_pred(input logic [6:0] s);
    return s[6] ^ s[5];
  endfunction

  // Error count increment that sticks at all-ones.
  function automatic logic [ERR_W-1:0] err_sat_inc(input logic [ERR_W-1:0] v);
    return (v == ERR_MAX) ? v : v + ERR_W'(1);
  endfunction

  // Bit count increment that sticks at 16'hFFFF.
  function automatic logic [15:0] bit_sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_e           state_q, state_d;
  logic [6:0]       sr_q, sr_d;
  logic [2:0]       fill_q, fill_d;
  logic [7:0]       match_q, match_d;
  logic [7:0]       wbit_q, wbit_d;
  logic [7:0]       werr_q, werr_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             err_pulse_q, err_pulse_d;
  logic             locked_q, locked_d;
`ifdef TTFIR_CHK_BITCNT_EN
  logic [15:0]      bit_cnt_q, bit_cnt_d;
  logic [15:0]      bit_cnt_nx_s;
`endif

  logic             pred_s;
  logic             mismatch_s;
  logic [7:0]       match_inc_s;
  logic [7:0]       wbit_inc_s;
  logic [7:0]       werr_inc_s;
  logic [ERR_W-1:0] err_cnt_nx_s;

  assign pred_s      = prbs7_pred(sr_q);
  assign mismatch_s  = bus.y_in ^ pred_s;
  assign match_inc_s = match_q + 8'd1;
  assign wbit_inc_s  = wbit_q + 8'd1;
  // Window error count including the bit being sampled now.
  assign werr_inc_s  = werr_q + {7'd0, mismatch_s};

  // Next-state logic: hunt/lock FSM, reference register and all counters.
  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    fill_d       = fill_q;
    match_d      = match_q;
    wbit_d       = wbit_q;
    werr_d       = werr_q;
    err_cnt_nx_s = err_cnt_q;
    err_pulse_d  = 1'b0;
`ifdef TTFIR_CHK_BITCNT_EN
    bit_cnt_nx_s = bit_cnt_q;
`endif

    if (bus.y_valid) begin
      case (state_q)
        ST_HUNT: begin
          sr_d = {sr_q[5:0], bus.y_in};
          if (fill_q != 3'd7) begin
            // sr does not yet hold 7 received bits: no prediction possible.
            fill_d = fill_q + 3'd1;
          end else if (mismatch_s) begin
            match_d = 8'd0;
          end else if (match_inc_s == LOCK_C) begin
            state_d = ST_LOCKED;
            match_d = 8'd0;
            wbit_d  = 8'd0;
            werr_d  = 8'd0;
          end else begin
            match_d = match_inc_s;
          end
        end

        ST_LOCKED: begin
          // Reference free-runs; received bits no longer enter sr.
          sr_d         = {sr_q[5:0], pred_s};
          err_pulse_d  = mismatch_s;
          err_cnt_nx_s = mismatch_s ? err_sat_inc(err_cnt_q) : err_cnt_q;
`ifdef TTFIR_CHK_BITCNT_EN
          bit_cnt_nx_s = bit_sat_inc(bit_cnt_q);
`endif
          if (werr_inc_s >= LOSS_C) begin
            state_d = ST_HUNT;
            fill_d  = 3'd0;
            match_d = 8'd0;
            wbit_d  = 8'd0;
            werr_d  = 8'd0;
          end else if (wbit_inc_s == WIN_C) begin
            // Last bit of the window: its error was already judged above.
            wbit_d = 8'd0;
            werr_d = 8'd0;
          end else begin
            wbit_d = wbit_inc_s;
            werr_d = werr_inc_s;
          end
        end

        default: begin
          state_d = ST_HUNT;
          fill_d  = 3'd0;
          match_d = 8'd0;
          wbit_d  = 8'd0;
          werr_d  = 8'd0;
        end
      endcase
    end else begin
      // No valid bit: everything holds, err_pulse drops.
      state_d = state_q;
    end

    // clr beats a simultaneous error on the count; err_pulse is unaffected.
    if (bus.clr) begin
      err_cnt_d = '0;
`ifdef TTFIR_CHK_BITCNT_EN
      bit_cnt_d = 16'd0;
`endif
    end else begin
      err_cnt_d = err_cnt_nx_s;
`ifdef TTFIR_CHK_BITCNT_EN
      bit_cnt_d = bit_cnt_nx_s;
`endif
    end

    locked_d = (state_d == ST_LOCKED);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_HUNT;
      sr_q        <= 7'd0;
      fill_q      <= 3'd0;
      match_q     <= 8'd0;
      wbit_q      <= 8'd0;
      werr_q      <= 8'd0;
      err_cnt_q   <= '0;
      err_pulse_q <= 1'b0;
      locked_q    <= 1'b0;
`ifdef TTFIR_CHK_BITCNT_EN
      bit_cnt_q   <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      wbit_q      <= wbit_d;
      werr_q      <= werr_d;
      err_cnt_q   <= err_cnt_d;
      err_pulse_q <= err_pulse_d;
      locked_q    <= locked_d;
`ifdef TTFIR_CHK_BITCNT_EN
      bit_cnt_q   <= bit_cnt_d;
`endif
    end
  end

  assign bus.locked    = locked_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_cnt   = err_cnt_q;
`ifdef TTFIR_CHK_BITCNT_EN
  assign bus.bit_cnt   = bit_cnt_q;
`endif

endmodule

// File: tb/tb_ttfir_prbs_checker.sv
// ---------------------------------------------------------------------------
// tb_ttfir_prbs_checker
// Drives PRBS7 streams (with injected errors, valid gaps, clears and resets)
// into ttfir_prbs_checker. Each driven cycle pushes the expected outputs of a
// behavioural model onto a scoreboard queue; the entry is popped and compared
// once the DUT edge has produced its outputs. Scenario-level checks (lock
// latency, final counts) use constants taken from the block description.
// ---------------------------------------------------------------------------
module tb_ttfir_prbs_checker;

  localparam int ERR_W = 8;
  localparam int LOCK_N = 16;
  localparam int WIN_N = 32;
  localparam int LOSS_N = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ttfir_prbs_checker_if #(.ERR_W(ERR_W)) bus_if ();

  ttfir_prbs_checker #(
    .LOCK_COUNT (LOCK_N),
    .WIN        (WIN_N),
    .LOSS_THRESH(LOSS_N),
    .ERR_W      (ERR_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  typedef struct {
    logic             lk;
    logic             ep;
    logic [ERR_W-1:0] ec;
    logic [15:0]      bc;
  } exp_t;

  exp_t sb_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  bit         m_locked;
  int         m_fill, m_match, m_wbit, m_werr, m_err, m_bc;
  bit         m_ep;
  logic [6:0] m_hist;

  // PRBS7 source register
  logic [6:0] g;

  task automatic check_val(input string tag, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0; m_fill = 0; m_match = 0; m_wbit = 0; m_werr = 0;
    m_err = 0; m_bc = 0; m_ep = 1'b0; m_hist = 7'd0;
  endtask

  task automatic model_step(input logic y, input logic v, input logic c);
    logic p;
    m_ep = 1'b0;
    if (v) begin
      p = m_hist[6] ^ m_hist[5];
      if (!m_locked) begin
        if (m_fill < 7) m_fill++;
        else if (y == p) begin
          m_match++;
          if (m_match == LOCK_N) begin
            m_locked = 1'b1; m_match = 0; m_wbit = 0; m_werr = 0;
          end
        end else m_match = 0;
        m_hist = {m_hist[5:0], y};
      end else begin
        m_hist = {m_hist[5:0], p};
        if (m_bc < 65535) m_bc++;
        m_wbit++;
        if (y != p) begin
          m_ep = 1'b1;
          if (m_err < 255) m_err++;
          m_werr++;
        end
        if (m_werr >= LOSS_N) begin
          m_locked = 1'b0; m_fill = 0; m_match = 0; m_wbit = 0; m_werr = 0;
        end else if (m_wbit == WIN_N) begin
          m_wbit = 0; m_werr = 0;
        end
      end
    end
    if (c) begin
      m_err = 0;
      m_bc  = 0;
    end
  endtask

  task automatic gen_bit(output logic b);
    b = g[6] ^ g[5];
    g = {g[5:0], b};
  endtask

  // One clock: drive inputs, predict, wait for the edge, compare.
  task automatic cycle(input logic y, input logic v, input logic c);
    exp_t e;
    bus_if.y_in    = y;
    bus_if.y_valid = v;
    bus_if.clr     = c;
    model_step(y, v, c);
    e.lk = m_locked;
    e.ep = m_ep;
    e.ec = ERR_W'(m_err);
    e.bc = 16'(m_bc);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_val("sb_locked", int'(bus_if.locked), int'(e.lk));
    check_val("sb_err_pulse", int'(bus_if.err_pulse), int'(e.ep));
    check_val("sb_err_cnt", int'(bus_if.err_cnt), int'(e.ec));
`ifdef TTFIR_CHK_BITCNT_EN
    check_val("sb_bit_cnt", int'(bus_if.bit_cnt), int'(e.bc));
`endif
    bus_if.clr = 1'b0;
  endtask

  task automatic send_clean(input int n);
    logic b;
    for (int i = 0; i < n; i++) begin
      gen_bit(b);
      cycle(b, 1'b1, 1'b0);
    end
  endtask

  // Feed clean bits until locked is seen; returns the number of bits used.
  task automatic relock_count(output int cnt);
    logic b;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      gen_bit(b);
      cycle(b, 1'b1, 1'b0);
      cnt++;
      if (bus_if.locked) break;
    end
  endtask

  initial begin
    logic b;
    int   cnt, pulses, vcount;

    model_reset();
    g              = 7'h7F;
    rst            = 1'b0;
    bus_if.y_in    = 1'b0;
    bus_if.y_valid = 1'b0;
    bus_if.clr     = 1'b0;

    // Reset held with toggling inputs
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus_if.y_in    = 1'(i);
      bus_if.y_valid = ~bus_if.y_valid;
      @(posedge clk);
      #1;
      check_val("rst_locked", int'(bus_if.locked), 0);
      check_val("rst_err_pulse", int'(bus_if.err_pulse), 0);
      check_val("rst_err_cnt", int'(bus_if.err_cnt), 0);
    end
    @(negedge clk);
    rst = 1'b1;

    // Clean stream: lock on valid bit 23, no errors over 500 bits
    cnt = 0;
    for (int i = 1; i <= 500; i++) begin
      gen_bit(b);
      cycle(b, 1'b1, 1'b0);
      if (cnt == 0 && bus_if.locked) cnt = i;
    end
    check_val("lock_bit", cnt, 23);
    check_val("clean_err_cnt", int'(bus_if.err_cnt), 0);

    // Single inverted bit while locked
    pulses = 0;
    gen_bit(b);
    cycle(~b, 1'b1, 1'b0);
    if (bus_if.err_pulse) pulses++;
    for (int i = 0; i < 5; i++) begin
      gen_bit(b);
      cycle(b, 1'b1, 1'b0);
      if (bus_if.err_pulse) pulses++;
    end
    check_val("single_pulses", pulses, 1);
    check_val("single_err_cnt", int'(bus_if.err_cnt), 1);
    check_val("single_locked", int'(bus_if.locked), 1);

    // Same with y_valid gaps, after clearing the count
    gen_bit(b);
    cycle(b, 1'b1, 1'b1);
    check_val("clr_err_cnt", int'(bus_if.err_cnt), 0);
    pulses = 0;
    vcount = 0;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        vcount++;
        gen_bit(b);
        cycle((vcount == 10) ? ~b : b, 1'b1, 1'b0);
      end else begin
        cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end
      if (bus_if.err_pulse) pulses++;
    end
    if (vcount < 10) begin
      gen_bit(b);
      cycle(~b, 1'b1, 1'b0);
      if (bus_if.err_pulse) pulses++;
    end
    check_val("gap_pulses", pulses, 1);
    check_val("gap_err_cnt", int'(bus_if.err_cnt), 1);
    check_val("gap_locked", int'(bus_if.locked), 1);

    // Four errors inside one window -> loss, then relock after 23 bits
    gen_bit(b);
    cycle(b, 1'b1, 1'b1);
    for (int i = 0; i < 64 && m_wbit != 0; i++) send_clean(1);
    for (int i = 0; i < 7; i++) begin
      gen_bit(b);
      cycle((i % 2 == 0) ? ~b : b, 1'b1, 1'b0);
      if (i == 4) check_val("pre_loss_locked", int'(bus_if.locked), 1);
      if (i == 6) check_val("loss_locked", int'(bus_if.locked), 0);
    end
    relock_count(cnt);
    check_val("relock_bits", cnt, 23);
    check_val("relock_err_cnt", int'(bus_if.err_cnt), 4);

    // Error every 11th bit (at most 3 per window): saturate, no loss
    for (int i = 1; i <= 3002; i++) begin
      gen_bit(b);
      cycle((i % 11 == 0) ? ~b : b, 1'b1, 1'b0);
    end
    check_val("sat_err_cnt", int'(bus_if.err_cnt), 255);
    check_val("sat_locked", int'(bus_if.locked), 1);
    gen_bit(b);
    cycle(~b, 1'b1, 1'b1);
    check_val("clr_err_cnt_win", int'(bus_if.err_cnt), 0);
    check_val("clr_err_pulse", int'(bus_if.err_pulse), 1);

    // Asynchronous reset mid-LOCKED with a non-zero count
    send_clean(12);
    gen_bit(b);
    cycle(~b, 1'b1, 1'b0);
    check_val("prerst_err_cnt", int'(bus_if.err_cnt), 1);
    check_val("prerst_locked", int'(bus_if.locked), 1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_val("arst_locked", int'(bus_if.locked), 0);
    check_val("arst_err_pulse", int'(bus_if.err_pulse), 0);
    check_val("arst_err_cnt", int'(bus_if.err_cnt), 0);
`ifdef TTFIR_CHK_BITCNT_EN
    check_val("arst_bit_cnt", int'(bus_if.bit_cnt), 0);
`endif
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    relock_count(cnt);
    check_val("post_rst_relock_bits", cnt, 23);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
